// File: rtl/irq_ctrl.sv
// 8-source interrupt controller: synchronized sources, edge/level pending, mask, fixed priority, ACK handshake.
// Optional overflow flags (register 5) are built when IRQ_CTRL_OVF_EN is defined.
module irq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] a,
    input  logic [7:0] d,
    input  logic       wdstb,
    output logic [7:0] O,
    input  logic [7:0] src,
    output logic       irq_out,
    output logic [2:0] vector
);

    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0]       sync_d1_q;
    logic [7:0]       src_sync_s;
    logic [7:0]       edge_s;
    logic [7:0]       pend_q, pend_d;
    logic [7:0]       mask_q, mode_q, ctrl_q;
    logic [7:0]       set_s, clr_s, ack_clr_s, req_s, ovf_rd_s;
    logic             wr_pend_s, wr_mask_s, wr_mode_s, wr_ctrl_s, wr_vec_s, wr_swset_s;
    logic [2:0]       cand_s;
    logic             any_s, ack_match_s, latched_ok_s, hold_done_s;
    state_t           state_q, state_d;
    logic             irq_q, irq_d;
    logic [2:0]       vector_q, vector_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Lowest set index wins; src[0] has the highest priority.
    function automatic logic [2:0] prio_idx(input logic [7:0] r);
        casez (r)
            8'b???????1: prio_idx = 3'd0;
            8'b??????10: prio_idx = 3'd1;
            8'b?????100: prio_idx = 3'd2;
            8'b????1000: prio_idx = 3'd3;
            8'b???10000: prio_idx = 3'd4;
            8'b??100000: prio_idx = 3'd5;
            8'b?1000000: prio_idx = 3'd6;
            8'b10000000: prio_idx = 3'd7;
            default:     prio_idx = 3'd0;
        endcase
    endfunction

    assign wr_pend_s  = wdstb && (a == 3'd0);
    assign wr_mask_s  = wdstb && (a == 3'd1);
    assign wr_mode_s  = wdstb && (a == 3'd2);
    assign wr_ctrl_s  = wdstb && (a == 3'd3);
    assign wr_vec_s   = wdstb && (a == 3'd4);
    assign wr_swset_s = wdstb && (a == 3'd6);

    assign src_sync_s = sync_q[SYNC_STAGES-1];
    assign edge_s     = src_sync_s & ~sync_d1_q;

    // Source synchronizer chain plus the delayed copy used for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            sync_d1_q <= 8'h00;
        end else begin
            sync_q[0] <= src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sync_d1_q <= src_sync_s;
        end
    end

    // Set/clear terms only touch edge-mode bits; level-mode bits simply follow the synchronized source.
    assign ack_clr_s = wr_vec_s ? (8'h01 << d[2:0]) : 8'h00;
    assign set_s     = (edge_s | (wr_swset_s ? d : 8'h00)) & mode_q;
    assign clr_s     = ((wr_pend_s ? d : 8'h00) | ack_clr_s) & mode_q;
    assign pend_d    = (mode_q & (set_s | (pend_q & ~clr_s))) | (~mode_q & src_sync_s);

    // Pending and configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 8'h00;
            mask_q <= 8'h00;
            mode_q <= 8'hFF;
            ctrl_q <= 8'h00;
        end else begin
            pend_q <= pend_d;
            if (wr_mask_s) mask_q <= d;
            if (wr_mode_s) mode_q <= d;
            if (wr_ctrl_s) ctrl_q <= d;
        end
    end

`ifdef IRQ_CTRL_OVF_EN
    logic [7:0] ovf_q, ovf_d;
    logic       wr_ovf_s;

    assign wr_ovf_s = wdstb && (a == 3'd5);
    assign ovf_d    = (set_s & pend_q) | (ovf_q & ~(wr_ovf_s ? d : 8'h00));
    assign ovf_rd_s = ovf_q;

    // Overflow flags: a new event landing on an already-pending edge bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 8'h00;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`else
    assign ovf_rd_s = 8'h00;
`endif

    assign req_s        = pend_q & mask_q;
    assign cand_s       = prio_idx(req_s);
    assign any_s        = (|req_s) & ctrl_q[7];
    assign ack_match_s  = wr_vec_s && (d[2:0] == vector_q);
    assign latched_ok_s = pend_q[vector_q] & mask_q[vector_q];
    assign hold_done_s  = (cnt_q == {CNT_W{1'b0}});

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            irq_q    <= 1'b0;
            vector_q <= 3'd0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            vector_q <= vector_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; an expired holdoff re-arbitrates immediately like IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_s) state_d = ST_REQ;
                else       state_d = ST_IDLE;
            end
            ST_REQ: begin
                if (!ctrl_q[7])         state_d = ST_IDLE;
                else if (ack_match_s)   state_d = ST_HOLD;
                else if (!latched_ok_s) state_d = ST_IDLE;
                else                    state_d = ST_REQ;
            end
            ST_HOLD: begin
                if (!hold_done_s) state_d = ST_HOLD;
                else if (any_s)   state_d = ST_REQ;
                else              state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values: vector is latched on entry to REQ and held until it is left.
    always_comb begin
        irq_d    = (state_d == ST_REQ);
        vector_d = 3'd0;
        cnt_d    = cnt_q;
        if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
            vector_d = cand_s;
        end else if (state_d == ST_REQ) begin
            vector_d = vector_q;
        end else begin
            vector_d = 3'd0;
        end
        if ((state_d == ST_HOLD) && (state_q != ST_HOLD)) begin
            cnt_d = HOLD_LOAD;
        end else if ((state_q == ST_HOLD) && !hold_done_s) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign irq_out = irq_q;
    assign vector  = vector_q;

    // Combinational register read mux.
    always_comb begin
        O = 8'h00;
        case (a)
            3'd0:    O = pend_q;
            3'd1:    O = mask_q;
            3'd2:    O = mode_q;
            3'd3:    O = ctrl_q;
            3'd4:    O = {(state_q == ST_REQ), 4'b0000, vector_q};
            3'd5:    O = ovf_rd_s;
            3'd6:    O = src_sync_s;
            3'd7:    O = 8'h5A;
            default: O = 8'h00;
        endcase
    end

endmodule
